// File: rtl/vga_pkg.sv
// Shared types and default VGA 640x480@60 timing for the sprite display path.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int CNT_W        = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int frame_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Stage-0 raster counters with combinational sync and active-region decode.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [CNT_W-1:0] o_h_count,
  output logic [CNT_W-1:0] o_v_count,
  output logic             o_hsync_n,
  output logic             o_vsync_n,
  output logic             o_active
);

  localparam int H_TOTAL = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == CNT_W'(H_TOTAL - 1)) begin
      r_h <= '0;
      r_v <= (r_v == CNT_W'(V_TOTAL - 1)) ? '0 : r_v + CNT_W'(1);
    end else begin
      r_h <= r_h + CNT_W'(1);
    end
  end

  assign o_h_count = r_h;
  assign o_v_count = r_v;
  assign o_hsync_n = !((r_h >= CNT_W'(H_ACTIVE + H_FP)) &&
                       (r_h <= CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1)));
  assign o_vsync_n = !((r_v >= CNT_W'(V_ACTIVE + V_FP)) &&
                       (r_v <= CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1)));
  assign o_active  = (r_h < CNT_W'(H_ACTIVE)) && (r_v < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/sprite_frame_compositor.sv
// VGA timing plus fixed-priority compositing of solid rectangular sprites whose
// positions are shadow-latched once per frame at the start of vertical blanking.
module sprite_frame_compositor
  import vga_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 32,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP
) (
  input  logic                             vga_clock,
  input  logic                             reset,
  input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_y,
  input  logic [NUM_SPRITES-1:0]           sprite_enable,
  input  logic [NUM_SPRITES*12-1:0]        sprite_color,
  input  logic [11:0]                      bg_color,
  output logic                             hsync,
  output logic                             vsync,
  output logic [3:0]                       vga_red,
  output logic [3:0]                       vga_green,
  output logic [3:0]                       vga_blue,
  output logic                             frame_start,
  output logic [9:0]                       pixel_x,
  output logic [9:0]                       pixel_y
);

  localparam logic signed [COORD_W:0] W_SPAN_X = signed'((COORD_W+1)'(SPRITE_W));
  localparam logic signed [COORD_W:0] W_SPAN_Y = signed'((COORD_W+1)'(SPRITE_H));

  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_hsync_n;
  logic             w_vsync_n;
  logic             w_active;
  logic             w_latch;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .i_clk     (vga_clock),
    .i_rst     (reset),
    .o_h_count (w_h),
    .o_v_count (w_v),
    .o_hsync_n (w_hsync_n),
    .o_vsync_n (w_vsync_n),
    .o_active  (w_active)
  );

  assign pixel_x = w_h;
  assign pixel_y = w_v;
  assign w_latch = (w_h == '0) && (w_v == CNT_W'(V_ACTIVE));

  logic [NUM_SPRITES*COORD_W-1:0] r_shadow_x;
  logic [NUM_SPRITES*COORD_W-1:0] r_shadow_y;
  logic [NUM_SPRITES-1:0]         r_shadow_en;
  logic [NUM_SPRITES*12-1:0]      r_shadow_color;

  // Shadow copies only move at the first blanking line, so the visible frame never tears.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_shadow_x     <= '0;
      r_shadow_y     <= '0;
      r_shadow_en    <= '0;
      r_shadow_color <= '0;
    end else if (w_latch) begin
      r_shadow_x     <= sprite_x;
      r_shadow_y     <= sprite_y;
      r_shadow_en    <= sprite_enable;
      r_shadow_color <= sprite_color;
    end
  end

  logic signed [COORD_W:0] w_h_s;
  logic signed [COORD_W:0] w_v_s;
  logic [NUM_SPRITES-1:0]  w_hit;

  assign w_h_s = signed'({{(COORD_W+1-CNT_W){1'b0}}, w_h});
  assign w_v_s = signed'({{(COORD_W+1-CNT_W){1'b0}}, w_v});

  // One extra bit keeps x+SPRITE_W from wrapping for coordinates near the signed limit.
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_hit
    logic signed [COORD_W:0] w_x;
    logic signed [COORD_W:0] w_y;
    assign w_x = signed'({r_shadow_x[gi*COORD_W+COORD_W-1], r_shadow_x[gi*COORD_W +: COORD_W]});
    assign w_y = signed'({r_shadow_y[gi*COORD_W+COORD_W-1], r_shadow_y[gi*COORD_W +: COORD_W]});
    assign w_hit[gi] = r_shadow_en[gi] &&
                       (w_h_s >= w_x) && (w_h_s < w_x + W_SPAN_X) &&
                       (w_v_s >= w_y) && (w_v_s < w_y + W_SPAN_Y);
  end

  // Stage 1: hit vector, blanking/sync decode and background registered together.
  logic [NUM_SPRITES-1:0] r_hit_p1;
  logic                   r_active_p1;
  logic                   r_hsync_p1;
  logic                   r_vsync_p1;
  logic [11:0]            r_bg_p1;
  logic                   r_frame_start_p1;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_hit_p1         <= '0;
      r_active_p1      <= 1'b0;
      r_hsync_p1       <= 1'b1;
      r_vsync_p1       <= 1'b1;
      r_bg_p1          <= '0;
      r_frame_start_p1 <= 1'b0;
    end else begin
      r_hit_p1         <= w_hit;
      r_active_p1      <= w_active;
      r_hsync_p1       <= w_hsync_n;
      r_vsync_p1       <= w_vsync_n;
      r_bg_p1          <= bg_color;
      r_frame_start_p1 <= w_latch;
    end
  end

  assign frame_start = r_frame_start_p1;

  rgb444_t w_rgb;

  always_comb begin
    w_rgb = rgb444_t'(r_bg_p1);
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (r_hit_p1[i]) w_rgb = rgb444_t'(r_shadow_color[i*12 +: 12]);
    end
    if (!r_active_p1) w_rgb = '0;
  end

  // Stage 2: colour and syncs leave on the same edge.
  rgb444_t r_rgb_p2;
  logic    r_hsync_p2;
  logic    r_vsync_p2;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      r_rgb_p2   <= '0;
      r_hsync_p2 <= 1'b1;
      r_vsync_p2 <= 1'b1;
    end else begin
      r_rgb_p2   <= w_rgb;
      r_hsync_p2 <= r_hsync_p1;
      r_vsync_p2 <= r_vsync_p1;
    end
  end

  assign hsync     = r_hsync_p2;
  assign vsync     = r_vsync_p2;
  assign vga_red   = r_rgb_p2.r;
  assign vga_green = r_rgb_p2.g;
  assign vga_blue  = r_rgb_p2.b;

endmodule

// File: tb/tb_sprite_frame_compositor.sv
// Scoreboard bench: a pixel-level reference model predicts every output pixel, sync and frame pulse.
module tb_sprite_frame_compositor;

  localparam int N   = 4;
  localparam int CW  = 32;
  localparam int SW  = 16;
  localparam int SH  = 16;
  localparam int HA  = 64, HFP = 4, HS = 8, HBP = 4;
  localparam int VA  = 48, VFP = 2, VS = 2, VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FR  = HT * VT;

  logic              vga_clock = 1'b0;
  logic              reset = 1'b0;
  logic [N*CW-1:0]   sprite_x = '0;
  logic [N*CW-1:0]   sprite_y = '0;
  logic [N-1:0]      sprite_enable = '0;
  logic [N*12-1:0]   sprite_color = '0;
  logic [11:0]       bg_color = '0;
  logic              hsync, vsync, frame_start;
  logic [3:0]        vga_red, vga_green, vga_blue;
  logic [9:0]        pixel_x, pixel_y;

  sprite_frame_compositor #(
    .NUM_SPRITES (N), .COORD_W (CW), .SPRITE_W (SW), .SPRITE_H (SH),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP)
  ) dut (
    .vga_clock     (vga_clock),
    .reset         (reset),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .sprite_enable (sprite_enable),
    .sprite_color  (sprite_color),
    .bg_color      (bg_color),
    .hsync         (hsync),
    .vsync         (vsync),
    .vga_red       (vga_red),
    .vga_green     (vga_green),
    .vga_blue      (vga_blue),
    .frame_start   (frame_start),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y)
  );

  always #5 vga_clock = ~vga_clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint      m_x [N];
  longint      m_y [N];
  bit          m_en [N];
  logic [11:0] m_col [N];
  logic [13:0] exp_q [$];
  bit          fs_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int h, input int v);
    logic [11:0] c;
    bit found;
    if (h >= HA || v >= VA) return 12'h000;
    c = bg_color;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && m_en[i] && h >= m_x[i] && h < m_x[i] + SW && v >= m_y[i] && v < m_y[i] + SH) begin
        c = m_col[i];
        found = 1'b1;
      end
    end
    return c;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 1'b0; m_col[i] = 12'h000;
    end
  endtask

  // Reference model: predicts the output for the raster position present at each edge.
  initial begin
    int h, v;
    bit hs, vs, lat;
    clear_model();
    forever begin
      @(posedge vga_clock);
      if (!reset) begin
        h   = cyc % HT;
        v   = (cyc / HT) % VT;
        hs  = !(h >= HA + HFP && h < HA + HFP + HS);
        vs  = !(v >= VA + VFP && v < VA + VFP + VS);
        lat = (h == 0 && v == VA);
        exp_q.push_back({ref_pixel(h, v), hs, vs});
        fs_q.push_back(lat);
        if (lat) begin
          for (int i = 0; i < N; i++) begin
            m_x[i]   = longint'($signed(sprite_x[i*CW +: CW]));
            m_y[i]   = longint'($signed(sprite_y[i*CW +: CW]));
            m_en[i]  = sprite_enable[i];
            m_col[i] = sprite_color[i*12 +: 12];
          end
        end
        cyc++;
      end
    end
  end

  // Monitor: pops predictions as the DUT pipeline delivers them.
  initial begin
    forever begin
      @(negedge vga_clock);
      if (!reset) begin
        check("pixel_xy", {12'h0, pixel_y, pixel_x}, {12'h0, 10'((cyc / HT) % VT), 10'(cyc % HT)});
        if (fs_q.size() >= 1) check("frame_start", {31'h0, frame_start}, {31'h0, fs_q.pop_front()});
        if (exp_q.size() >= 2)
          check("pixel_rgb_sync", {18'h0, vga_red, vga_green, vga_blue, hsync, vsync}, {18'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic set_sprite(input int i, input int x, input int y, input bit en, input logic [11:0] c);
    sprite_x[i*CW +: CW] = x;
    sprite_y[i*CW +: CW] = y;
    sprite_enable[i]     = en;
    sprite_color[i*12 +: 12] = c;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++)
      set_sprite(i, int'($urandom_range(0, HA + 40)) - 20, int'($urandom_range(0, VA + 40)) - 20,
                 1'($urandom_range(0, 1)), 12'($urandom));
    bg_color = 12'($urandom);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge vga_clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsync"}, {31'h0, hsync}, 32'd1);
    check({tag, "_vsync"}, {31'h0, vsync}, 32'd1);
    check({tag, "_rgb"}, {20'h0, vga_red, vga_green, vga_blue}, 32'h0);
    check({tag, "_frame_start"}, {31'h0, frame_start}, 32'd0);
    check({tag, "_pixel_xy"}, {12'h0, pixel_y, pixel_x}, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst0");

    // First shadow contents: single red sprite over blue background.
    set_sprite(0, 10, 5, 1'b1, 12'hF00);
    for (int i = 1; i < N; i++) set_sprite(i, 0, 0, 1'b0, 12'h000);
    bg_color = 12'h00F;
    repeat (2) @(negedge vga_clock);
    reset = 1'b0;

    // Mid-frame change: must not show until the following latch.
    wait_until(FR + 20 * HT);
    set_sprite(0, 20, 20, 1'b1, 12'h0F0);
    set_sprite(1, -8, 2, 1'b1, 12'h0AA);
    set_sprite(2, 20, 20, 1'b1, 12'hFFF);
    set_sprite(3, HA - 4, 30, 1'b1, 12'h5A5);

    wait_until(2 * FR + 10 * HT + 5);
    set_sprite(0, 30, 10, 1'b1, 12'h123);
    set_sprite(1, 30, 10, 1'b1, 12'h456);
    set_sprite(2, 30, 10, 1'b1, 12'h789);
    set_sprite(3, 32'sh7FFF_FFF8, 12, 1'b1, 12'hFFF);

    wait_until(3 * FR + 30 * HT);
    for (int i = 0; i < N; i++) set_sprite(i, 5, 40, 1'b1, 12'(12'h111 * (i + 1)));

    for (int f = 4; f < 7; f++) begin
      wait_until(f * FR + int'($urandom_range(0, VA * HT - 1)));
      randomize_inputs();
    end

    // Reset in the middle of the visible area.
    wait_until(7 * FR + 24 * HT + 30);
    reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    exp_q.delete();
    fs_q.delete();
    cyc = 0;
    clear_model();
    repeat (3) @(negedge vga_clock);
    reset = 1'b0;

    wait_until(FR + 100);
    randomize_inputs();
    wait_until(2 * FR + 50);
    repeat (3) @(negedge vga_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
